// File: rtl/uart_ctrl_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
package uart_ctrl_pkg;
    // 1 arm cycle + 1 start bit + 8 data bits
    localparam int START_HOLD_CYCLES = 10;
    localparam int UART_DATA_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after pointer, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any && req[wrap_idx(pointer, k)]) begin
                any       = 1'b1;
                grant_idx = wrap_idx(pointer, k);
            end
        end
        if (enable && any) grant[grant_idx] = 1'b1;
        any = any && enable;
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 transmitter; this block owns frame timing
// because the transmitter exposes no busy indication.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 1,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [8*NUM_REQ-1:0]     req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     uart_start,
    output logic [UART_DATA_W-1:0]   uart_data,
    output logic                     busy,
    output logic [IDW-1:0]           grant_id,
    output logic [15:0]              frame_count
);
    localparam int CNT_MAX = (START_HOLD_CYCLES > GAP_CYCLES) ? START_HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    state_t                                  state;
    logic [CW-1:0]                           cnt;
    logic [IDW-1:0]                          pointer;
    logic [IDW-1:0]                          win;
    logic                                    any;
    logic [NUM_REQ-1:0][UART_DATA_W-1:0]     bytes;

    assign bytes = req_data;
    assign busy  = (state != IDLE);

    rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
        .req       (req_valid),
        .pointer   (pointer),
        .enable    (state == IDLE),
        .grant     (req_ready),
        .grant_idx (win),
        .any       (any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pointer     <= IDW'(NUM_REQ - 1);
            uart_start  <= 1'b0;
            uart_data   <= '0;
            grant_id    <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    uart_data   <= bytes[win];
                    grant_id    <= win;
                    pointer     <= win;
                    frame_count <= frame_count + 16'd1;
                    cnt         <= CW'(START_HOLD_CYCLES - 1);
                    uart_start  <= 1'b1;
                    state       <= SEND;
                end
                SEND: if (cnt == '0) begin
                    uart_start <= 1'b0;
                    cnt        <= CW'(GAP_CYCLES - 1);
                    state      <= GAP;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                // Start stays low here so the transmitter finishes its stop bit.
                GAP: if (cnt == '0) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected frames, a monitor decodes them.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           uart_start;
    logic [7:0]     uart_data;
    logic           busy;
    logic [1:0]     grant_id;
    logic [15:0]    frame_count;

    logic [N-1:0]   v3;
    logic [8*N-1:0] d3;
    logic [N-1:0]   r3;
    logic           s3;
    logic [7:0]     ud3;
    logic           b3;
    logic [1:0]     g3;
    logic [15:0]    fc3;

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .uart_start(uart_start), .uart_data(uart_data),
        .busy(busy), .grant_id(grant_id), .frame_count(frame_count)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(3)) dut_gap3 (
        .clk(clk), .reset(reset), .req_valid(v3), .req_data(d3),
        .req_ready(r3), .uart_start(s3), .uart_data(ud3),
        .busy(b3), .grant_id(g3), .frame_count(fc3)
    );

    always #5 clk = ~clk;

    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } frame_t;

    frame_t exp_q[$];
    int     acc_tick_q[$];
    int     acc_id_q[$];
    int     last_acc_tick = -100;

    // Monitor: attached 8N1 line model, LSB first after arm and start-bit cycles.
    initial begin
        logic   prev;
        int     hi;
        logic   have;
        logic [7:0] rx;
        frame_t cur;
        prev = 1'b0; hi = 0; have = 1'b0; rx = '0; cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0; hi = 0; have = 1'b0;
            end else begin
                if (uart_start) begin
                    hi++;
                    if (!prev) begin
                        rx = '0;
                        if (exp_q.size() == 0) begin
                            checks++; errors++; have = 1'b0;
                            $display("FAIL unexpected_frame actual=%0h required=none", uart_data);
                        end else begin
                            cur  = exp_q.pop_front();
                            have = 1'b1;
                            check("grant_id", 32'(grant_id), 32'(cur.id));
                            check("uart_data", 32'(uart_data), 32'(cur.data));
                            check("start_latency", tick, last_acc_tick + 1);
                        end
                    end
                    if (hi >= 3 && hi <= 10) rx = {uart_data[hi-3], rx[7:1]};
                end else if (prev) begin
                    check("start_len", hi, 10);
                    if (have) check("rx_byte", 32'(rx), 32'(cur.data));
                    hi = 0;
                end
                prev = uart_start;
            end
        end
    end

    logic [N-1:0] acc   = '0;
    logic [N-1:0] hold  = '0;
    logic [N-1:0] raise = '0;

    task automatic step();
        @(negedge clk);
        req_valid = (req_valid & ~(acc & ~hold)) | raise;
        raise = '0;
        #1;
        acc = req_valid & req_ready;
        if (busy) check("ready_while_busy", 32'(req_ready), 0);
        if (acc != '0) begin
            last_acc_tick = tick;
            acc_tick_q.push_back(tick);
            for (int i = 0; i < N; i++) if (acc[i]) acc_id_q.push_back(i);
        end
    endtask

    task automatic wait_acc(input int n, input int budget);
        int b;
        b = 0;
        while (acc_id_q.size() < n && b < budget) begin
            step();
            b++;
        end
        if (acc_id_q.size() < n) check("accept_timeout", acc_id_q.size(), n);
    endtask

    task automatic do_reset();
        req_valid = '0; hold = '0; raise = '0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        acc = '0;
        acc_tick_q.delete(); acc_id_q.delete();
    endtask

    task automatic single_a5(input string tag);
        req_data[7:0] = 8'hA5;
        exp_q.push_back('{id: 2'd0, data: 8'hA5});
        raise = 4'b0001;
        step();
        check({tag, "_ready"}, 32'(req_ready), 32'h1);
        step();
        check({tag, "_count"}, 32'(frame_count), 1);
        check({tag, "_busy"}, 32'(busy), 1);
        repeat (12) step();
    endtask

    initial begin
        int t0;
        int rises[$];
        logic p3;
        reset = 1'b1; req_valid = '0; req_data = '0; v3 = '0; d3 = '0;
        repeat (3) @(negedge clk);
        check("rst_start", 32'(uart_start), 0);
        check("rst_data", 32'(uart_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_id), 0);
        check("rst_count", 32'(frame_count), 0);
        check("rst_count_g3", 32'(fc3), 0);
        reset = 1'b0;

        single_a5("s1");

        // All four at once after a fresh reset: served 0,1,2,3, 12 cycles apart.
        do_reset();
        req_data = 32'h4332_2110;
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{id: 2'(i), data: req_data[8*i +: 8]});
        raise = 4'b1111;
        wait_acc(4, 60);
        for (int i = 0; i < 4 && i < acc_id_q.size(); i++) begin
            check("s2_order", acc_id_q[i], i);
            if (i > 0) check("s2_spacing", acc_tick_q[i] - acc_tick_q[i-1], 12);
        end
        repeat (12) step();

        // req0 and req2 continuously valid alternate.
        acc_tick_q.delete(); acc_id_q.delete();
        req_data = 32'h00AA_0055;
        for (int k = 0; k < 8; k++)
            exp_q.push_back((k % 2) ? '{id: 2'd2, data: 8'hAA} : '{id: 2'd0, data: 8'h55});
        hold = 4'b0101; raise = 4'b0101;
        wait_acc(8, 120);
        hold = '0;
        step();
        req_valid = '0;
        for (int k = 0; k < 8 && k < acc_id_q.size(); k++)
            check("s3_alternate", acc_id_q[k], (k % 2) ? 2 : 0);
        repeat (12) step();

        // Late arrival of req1 during req0's frame.
        acc_tick_q.delete(); acc_id_q.delete();
        req_data = 32'h0000_003C;
        exp_q.push_back('{id: 2'd0, data: 8'h3C});
        raise = 4'b0001;
        wait_acc(1, 5);
        repeat (4) step();
        req_data[15:8] = 8'hC3;
        exp_q.push_back('{id: 2'd1, data: 8'hC3});
        raise = 4'b0010;
        wait_acc(2, 30);
        if (acc_tick_q.size() >= 2) check("s4_late_spacing", acc_tick_q[1] - acc_tick_q[0], 12);
        repeat (12) step();

        // Reset in the middle of a frame.
        acc_tick_q.delete(); acc_id_q.delete();
        req_data = 32'h7700_0000;
        exp_q.push_back('{id: 2'd3, data: 8'h77});
        raise = 4'b1000;
        wait_acc(1, 5);
        repeat (4) step();
        reset = 1'b1;
        step();
        check("s5_start", 32'(uart_start), 0);
        check("s5_busy", 32'(busy), 0);
        check("s5_count", 32'(frame_count), 0);
        check("s5_grant", 32'(grant_id), 0);
        reset = 1'b0;
        acc = '0;
        single_a5("s5b");

        // GAP_CYCLES=3 instance: counter wrap and 14-cycle period.
        @(negedge clk);
        force dut_gap3.frame_count = 16'hFFFF;
        @(negedge clk);
        release dut_gap3.frame_count;
        @(negedge clk);
        check("g3_preload", 32'(fc3), 32'hFFFF);
        d3 = 32'h0099_0000;
        v3 = 4'b0100;
        #1;
        check("g3_ready", 32'(r3), 32'h4);
        @(negedge clk);
        check("g3_wrap", 32'(fc3), 0);
        check("g3_grant", 32'(g3), 2);
        check("g3_data", 32'(ud3), 32'h99);
        rises.push_back(tick);
        p3 = s3;
        for (int c = 0; c < 60 && rises.size() < 3; c++) begin
            @(negedge clk);
            if (s3 && !p3) rises.push_back(tick);
            p3 = s3;
        end
        check("g3_rises", rises.size(), 3);
        for (int i = 1; i < rises.size(); i++)
            check("g3_period", rises[i] - rises[i-1], 14);
        check("g3_count", 32'(fc3), 2);
        v3 = '0;

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter between NUM_REQ byte producers using round-robin arbitration.
- Sequences the transmitter's level-held start/data interface: holds start for the exact frame length, drops it for the release gap, then returns to arbitration.
- Sits between the system's message sources (status, debug, echo) and the UART transmitter; the transmitter has no busy output, so this block owns frame timing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 1, cycles start is held low after each frame before re-arbitration (>=1).
- IDW, $clog2(NUM_REQ), width of grant index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe (combinational).
- uart_start  out  1  to transmitter start input (registered).
- uart_data  out  8  to transmitter data input (registered, stable for the whole frame).
- busy  out  1  high whenever state != IDLE.
- grant_id  out  IDW  index of requester owning current or last frame.
- frame_count  out  16  frames issued, wraps at 0xFFFF->0.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - uart_start=0, uart_data=0x00, busy=0, grant_id=0, frame_count=0.
  - State=IDLE; RR pointer=NUM_REQ-1, so requester 0 has first priority.
- Handshake:
  - A byte transfers in a cycle with req_valid[i] && req_ready[i].
  - Once raised, req_valid must hold with stable data until accepted; the block never drops an accepted byte.
- Arbitration (IDLE only):
  - Winner is the first set req_valid scanning from pointer+1 upward, wrapping modulo NUM_REQ.
  - req_ready is one-hot of the winner in IDLE, otherwise all zero.
  - On accept: uart_data<=byte, grant_id<=winner, pointer<=winner, frame_count+1, state->SEND.
- States:
  - IDLE: uart_start=0. Wait for any valid.
  - SEND: uart_start=1 for exactly START_HOLD=10 cycles (1 arm, 1 start bit, 8 data bits); a down-counter counts them. Then uart_start<=0 and state->GAP.
  - GAP: uart_start=0 for GAP_CYCLES cycles. The transmitter sees start low while emitting the stop bit and returns idle. Then state->IDLE.
- Latency (accept at cycle A):
  - uart_start high on A+1..A+10, low from A+11.
  - With GAP_CYCLES=1: IDLE at A+12, earliest next accept A+12, next start A+13.
  - Minimum frame period 12 cycles; the stop bit lasts >=2 cycles.
- uart_data changes only on accept, so it is constant while uart_start is high.
- Simultaneous valids: exactly one accept per IDLE cycle; the others wait.
  - Fairness: each of N continuously valid requesters is served once per N frames.
- Single requester continuously valid: served back-to-back every 12 cycles (pointer wrap has no effect).
- Valid arriving during SEND/GAP: not accepted until IDLE. req_ready stays 0.
- Reset mid-frame:
  - Immediate return to reset values; in-flight byte abandoned.
  - System requirement: transmitter and this block share the same reset event, so neither side is left mid-frame.
- frame_count increments on accept, not on completion.

Decomposition:
- Package uart_ctrl_pkg:
  - START_HOLD_CYCLES=10 (tied to the 8-bit frame), UART_DATA_W=8.
  - State enum IDLE/SEND/GAP (2-bit).
- Sub-module rr_arbiter: parameter N.
  - Inputs: req, pointer, enable.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational; the pointer register lives in the top.

Test Plan:
- Single request: after reset, req_valid=4'b0001, data=0xA5 -> req_ready[0] same cycle; uart_start high exactly 10 cycles starting next cycle; uart_data=0xA5 throughout; bench-attached transmitter output decodes 0xA5; frame_count=1.
- Simultaneous requests: all four valid with 0x10,0x21,0x32,0x43, held until accepted -> acceptance order 0,1,2,3; accepts 12 cycles apart; grant_id follows 0..3.
- Fairness under load: req0 and req2 valid continuously -> frames alternate 0,2,0,2 over 8 frames; no requester starved.
- Late arrival: req1 raised mid-SEND of req0's frame -> req_ready stays 0 until IDLE; accepted 12 cycles after req0's accept.
- Reset mid-frame: assert reset at SEND cycle 5 -> next cycle uart_start=0, busy=0, frame_count=0; a subsequent request behaves exactly as the first scenario.
- Gap parameter: GAP_CYCLES=3, one requester continuously valid -> start-rise to start-rise period is 14 cycles; frame_count wraps from 0xFFFF to 0 when preloaded via forced state.
